// File: rtl/dm_param.sv
// ---------------------------------------------------------------------------
// dm_param
// Parametrised data memory for the Forth core's data/stack space. Word-wide
// RAM with byte-lane writes, a Req/Ready handshake and one-cycle read latency.
// After reset the whole array is cleared by a hardware sweep, one word per
// clock, during which no requests are accepted. Misaligned and out-of-range
// accesses are rejected and flagged with a one-cycle Fault pulse.
//
// Parameters
//   DW         data word width in bits (multiple of 8), NB = DW/8 byte lanes
//   AW         byte-address width
//   DEPTH_LOG2 log2 of the word count; LSB + DEPTH_LOG2 must not exceed AW
//
// Ports
//   Clk     clock, all state updates on the rising edge
//   Rst     synchronous active-high reset, priority over every other input
//   Req     access request, held by the master until Ready is sampled high
//   We      1 = write, 0 = read, sampled with Req
//   Addr    byte address; word index = Addr[LSB+DEPTH_LOG2-1:LSB]
//   WData   write data, lane k = WData[8k+7:8k]
//   ByteEn  per-lane write enables, ignored on reads
//   Ready   block accepts a request this cycle
//   Busy    reset zero-sweep in progress
//   RData   read data, valid with RValid, holds its value otherwise
//   RValid  one-cycle pulse, read result available
//   Fault   one-cycle pulse, accepted access was misaligned or out of range
// ---------------------------------------------------------------------------
module dm_param #(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic              We,
  input  logic [AW-1:0]     Addr,
  input  logic [DW-1:0]     WData,
  input  logic [DW/8-1:0]   ByteEn,
  output logic              Ready,
  output logic              Busy,
  output logic [DW-1:0]     RData,
  output logic              RValid,
  output logic              Fault
);

  localparam int NB    = DW / 8;
  localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DEPTH_LOG2-1:0]  ptr;
  logic [DW-1:0]          mem [DEPTH];

  logic [DEPTH_LOG2-1:0]  idx;
  logic                   misaligned;
  logic                   out_of_range;
  logic                   bad;
  logic                   accept;

  logic                   rvalid_q;
  logic                   fault_q;
  logic [DW-1:0]          rdata_q;

  assign idx = Addr[LSB +: DEPTH_LOG2];

  // With a single byte lane every address is aligned, so there are no
  // offset bits to test.
  generate
    if (LSB > 0) begin : g_align
      assign misaligned = |Addr[LSB-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // When the word index reaches the top address bit, every address maps to
  // a real word and nothing can be out of range.
  generate
    if (LSB + DEPTH_LOG2 < AW) begin : g_range
      assign out_of_range = |Addr[AW-1:LSB+DEPTH_LOG2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign bad    = misaligned | out_of_range;
  assign accept = Req & Ready;

  // State register. Reset always restarts the sweep from word 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    Busy      = 1'b0;
    case (state)
      CLEAR: begin
        Busy = 1'b1;
        if (ptr == PTR_LAST) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        Ready = 1'b1;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Sweep pointer. It wraps back to 0 after the last word, which leaves it
  // ready for the next sweep even without a reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + PTR_ONE;
    end
  end

  // Memory array. It has no reset of its own; the sweep clears it. Nothing
  // is written on a reset edge, so a write coinciding with Rst is dropped.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (accept && We && !bad) begin
        for (int k = 0; k < NB; k++) begin
          if (ByteEn[k]) begin
            mem[idx][8*k +: 8] <= WData[8*k +: 8];
          end
        end
      end
    end
  end

  // Read response. Only one access is accepted per cycle, so a read never
  // shares its accept edge with a write and the array value sampled here is
  // already the post-edge contents. RData keeps its last value between reads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept & ~We;
      fault_q  <= accept & bad;
      if (accept && !We) begin
        rdata_q <= bad ? '0 : mem[idx];
      end
    end
  end

  assign RValid = rvalid_q;
  assign Fault  = fault_q;
  assign RData  = rdata_q;

endmodule

// File: tb/tb_dm_param.sv
// ---------------------------------------------------------------------------
// tb_dm_param
// Directed self-checking bench for dm_param with DW=16, AW=16, DEPTH_LOG2=4.
// Inputs change 1 ns after a rising edge, outputs are sampled at that point,
// so each sample reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_dm_param;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req = 1'b0;
  logic        We = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] WData = '0;
  logic [1:0]  ByteEn = '0;
  logic        Ready;
  logic        Busy;
  logic [15:0] RData;
  logic        RValid;
  logic        Fault;

  int compared = 0;
  int mismatched = 0;

  dm_param #(
    .DW(16),
    .AW(16),
    .DEPTH_LOG2(4)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Req(Req),
    .We(We),
    .Addr(Addr),
    .WData(WData),
    .ByteEn(ByteEn),
    .Ready(Ready),
    .Busy(Busy),
    .RData(RData),
    .RValid(RValid),
    .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // Trace of every write the memory will accept on the coming edge.
  always @(negedge Clk) begin
    if (!Rst && Req && Ready && We) begin
      $display("[TB] write addr=%h data=%h en=%b", Addr, WData, ByteEn);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic we,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic [1:0] be);
    Req    = rq;
    We     = we;
    Addr   = a;
    WData  = d;
    ByteEn = be;
  endtask

  task automatic doWrite(input string tag, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] be,
                         input logic expFault);
    applyStimulus(1'b1, 1'b1, a, d, be);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    checkOutput($sformatf("%s.fault", tag), {31'b0, Fault}, {31'b0, expFault});
    checkOutput($sformatf("%s.rvalid", tag), {31'b0, RValid}, 32'd0);
  endtask

  task automatic doRead(input string tag, input logic [15:0] a,
                        input logic [15:0] expData, input logic expFault);
    applyStimulus(1'b1, 1'b0, a, 16'h0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    checkOutput($sformatf("%s.rvalid", tag), {31'b0, RValid}, 32'd1);
    checkOutput($sformatf("%s.rdata", tag), {16'b0, RData}, {16'b0, expData});
    checkOutput($sformatf("%s.fault", tag), {31'b0, Fault}, {31'b0, expFault});
  endtask

  // Counts consecutive Busy samples starting from the current one; notes any
  // Ready, RValid or Fault seen while the sweep is running.
  task automatic measureSweep(output int cycles, output logic sawActivity);
    cycles = 0;
    sawActivity = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!Busy) break;
      cycles++;
      if (Ready || RValid || Fault) sawActivity = 1'b1;
      tick();
    end
  endtask

  initial begin
    int   cycles;
    logic saw;

    // Reset with Req held high through the whole sweep.
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0, 2'b00);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checkOutput("rst.busy", {31'b0, Busy}, 32'd1);
    checkOutput("rst.ready", {31'b0, Ready}, 32'd0);
    checkOutput("rst.rvalid", {31'b0, RValid}, 32'd0);
    checkOutput("rst.fault", {31'b0, Fault}, 32'd0);
    checkOutput("rst.rdata", {16'b0, RData}, 32'd0);
    measureSweep(cycles, saw);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    checkOutput("sweep1.cycles", cycles, 32'd16);
    checkOutput("sweep1.activity", {31'b0, saw}, 32'd0);
    checkOutput("sweep1.ready", {31'b0, Ready}, 32'd1);
    checkOutput("sweep1.busy", {31'b0, Busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      doRead($sformatf("zero%0d", i), 16'(2 * i), 16'h0000, 1'b0);
    end

    // Full-word write followed immediately by a read of the same word.
    doWrite("wr6", 16'h0006, 16'hBEEF, 2'b11, 1'b0);
    doRead("raw6", 16'h0006, 16'hBEEF, 1'b0);
    doWrite("wr18", 16'h0018, 16'h7777, 2'b11, 1'b0);
    doRead("rd18", 16'h0018, 16'h7777, 1'b0);

    // Byte-lane merging and the empty enable mask.
    doWrite("wr4a", 16'h0004, 16'h1234, 2'b11, 1'b0);
    doWrite("wr4b", 16'h0004, 16'hABCD, 2'b10, 1'b0);
    doRead("lane4", 16'h0004, 16'hAB34, 1'b0);
    doWrite("wr4c", 16'h0004, 16'hFFFF, 2'b00, 1'b0);
    doRead("noen4", 16'h0004, 16'hAB34, 1'b0);
    doWrite("wr4d", 16'h0004, 16'h5566, 2'b01, 1'b0);
    doRead("lo4", 16'h0004, 16'hAB66, 1'b0);

    // Faulting accesses: misaligned read, out-of-range read and writes.
    doRead("rd6b", 16'h0006, 16'hBEEF, 1'b0);
    doRead("mis3", 16'h0003, 16'h0000, 1'b1);
    doRead("rd6c", 16'h0006, 16'hBEEF, 1'b0);
    doRead("oor40", 16'h0040, 16'h0000, 1'b1);
    doWrite("oor20", 16'h0020, 16'h5555, 2'b11, 1'b1);
    doRead("after20", 16'h0000, 16'h0000, 1'b0);
    doWrite("mis5", 16'h0005, 16'h9999, 2'b11, 1'b1);
    doRead("after5", 16'h0004, 16'hAB66, 1'b0);
    tick();
    checkOutput("faultpulse", {31'b0, Fault}, 32'd0);

    // Three reads on consecutive cycles.
    doWrite("wr0", 16'h0000, 16'h1111, 2'b11, 1'b0);
    doWrite("wr2", 16'h0002, 16'h2222, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0, 2'b00);
    checkOutput("b2b0.rvalid", {31'b0, RValid}, 32'd1);
    checkOutput("b2b0.rdata", {16'b0, RData}, 32'h1111);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0004, 16'h0, 2'b00);
    checkOutput("b2b1.rvalid", {31'b0, RValid}, 32'd1);
    checkOutput("b2b1.rdata", {16'b0, RData}, 32'h2222);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    checkOutput("b2b2.rvalid", {31'b0, RValid}, 32'd1);
    checkOutput("b2b2.rdata", {16'b0, RData}, 32'hAB66);
    tick();
    checkOutput("b2b.rvalid_end", {31'b0, RValid}, 32'd0);
    checkOutput("b2b.rdata_hold", {16'b0, RData}, 32'hAB66);

    // Reset part way through the sweep restarts it from word 0.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    repeat (7) tick();
    checkOutput("mid.busy", {31'b0, Busy}, 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    measureSweep(cycles, saw);
    checkOutput("sweep2.cycles", cycles, 32'd16);
    checkOutput("sweep2.activity", {31'b0, saw}, 32'd0);
    doRead("clr4", 16'h0004, 16'h0000, 1'b0);
    doRead("clr18", 16'h0018, 16'h0000, 1'b0);

    // Reset in the cycle after a read accept, with a faulting read also
    // requested on the reset edge: both responses must be dropped.
    doWrite("wr6r", 16'h0006, 16'h1357, 2'b11, 1'b0);
    doRead("rd6r", 16'h0006, 16'h1357, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0, 2'b00);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    checkOutput("rstrd.rvalid", {31'b0, RValid}, 32'd0);
    checkOutput("rstrd.fault", {31'b0, Fault}, 32'd0);
    checkOutput("rstrd.rdata", {16'b0, RData}, 32'd0);
    checkOutput("rstrd.busy", {31'b0, Busy}, 32'd1);
    measureSweep(cycles, saw);
    checkOutput("sweep3.cycles", cycles, 32'd16);
    doRead("clr6", 16'h0006, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
